// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Each grant runs ISSUE (address/write strobe) then RESP (read data + ack).
module mem_port_arbiter #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    output logic              a_ack,
    output logic [WIDTH-1:0]  a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_wdata,
    output logic              b_ack,
    output logic [WIDTH-1:0]  b_rdata,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              last_b_q, last_b_d;
    logic              mem_we_q, mem_we_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic              grant_a, grant_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_b_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_b_q    <= last_b_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_b_d    = last_b_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_a     = 1'b0;
        grant_b     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On a tie the port that was not served last wins.
                if (a_req && (!b_req || last_b_q)) begin
                    grant_a = 1'b1;
                end else if (b_req) begin
                    grant_b = 1'b1;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                last_b_d = owner_q[1];
                // Only the other port may chain straight into ISSUE.
                if (owner_q[0] && b_req) begin
                    grant_b = 1'b1;
                end else if (owner_q[1] && a_req) begin
                    grant_a = 1'b1;
                end else begin
                    owner_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                owner_d = '0;
                state_d = IDLE;
            end
        endcase

        if (grant_a) begin
            state_d     = ISSUE;
            owner_d     = 2'b01;
            mem_we_d    = a_we;
            mem_addr_d  = a_addr;
            mem_wdata_d = a_wdata;
        end else if (grant_b) begin
            state_d     = ISSUE;
            owner_d     = 2'b10;
            mem_we_d    = b_we;
            mem_addr_d  = b_addr;
            mem_wdata_d = b_wdata;
        end
    end

    assign a_ack     = (state_q == RESP) && owner_q[0];
    assign b_ack     = (state_q == RESP) && owner_q[1];
    assign a_rdata   = a_ack ? mem_rdata : '0;
    assign b_rdata   = b_ack ? mem_rdata : '0;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, b_ack, mem_we;
    logic [15:0] a_rdata, b_rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [1:0]  owner;
    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(16), .AWIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'hBEEF;
        mem[8'h01] = 16'hAAAA;
        mem[8'h02] = 16'hBBBB;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        cyc(); cyc();

        // 1: reset state, idle indefinitely
        chk("rst_owner", 32'(owner), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_acks", {a_ack, b_ack}, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_quiet", {owner, mem_we, a_ack, b_ack}, 0);
        end

        // 2: A read of 0x0010
        a_req = 1; a_we = 0; a_addr = 16'h0010;
        cyc();
        chk("rd_c1_addr", 32'(mem_addr), 32'h0010);
        chk("rd_c1_owner", 32'(owner), 1);
        chk("rd_c1_ack", 32'(a_ack), 0);
        cyc();
        chk("rd_c2_ack", {a_ack, b_ack}, 2'b10);
        chk("rd_c2_rdata", 32'(a_rdata), 32'hBEEF);
        a_req = 0;
        cyc();
        chk("rd_c3_ack", 32'(a_ack), 0);
        chk("rd_c3_owner", 32'(owner), 0);

        // 3: A write 0x1234 to 0x0020; late wdata change must not leak in
        a_req = 1; a_we = 1; a_addr = 16'h0020; a_wdata = 16'h1234;
        cyc();
        chk("wr_c1_we", 32'(mem_we), 1);
        chk("wr_c1_addr", 32'(mem_addr), 32'h0020);
        chk("wr_c1_wdata", 32'(mem_wdata), 32'h1234);
        a_wdata = 16'hFFFF; a_addr = 16'h0030;
        cyc();
        chk("wr_c2_we", 32'(mem_we), 0);
        chk("wr_c2_acks", {a_ack, b_ack}, 2'b10);
        chk("wr_c2_wdata", 32'(mem_wdata), 32'h1234);
        a_req = 0; a_we = 0;
        cyc();
        chk("wr_c3_ack", 32'(a_ack), 0);
        chk("wr_mem", 32'(mem[8'h20]), 32'h1234);

        // 4: tie right after reset, A first then B back-to-back
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        a_req = 1; a_addr = 16'h0001; b_req = 1; b_we = 0; b_addr = 16'h0002;
        cyc();
        chk("tie_c1_owner", 32'(owner), 1);
        chk("tie_c1_addr", 32'(mem_addr), 1);
        cyc();
        chk("tie_c2_owner", 32'(owner), 1);
        chk("tie_c2_acks", {a_ack, b_ack}, 2'b10);
        chk("tie_c2_rdata", 32'(a_rdata), 32'hAAAA);
        a_req = 0;
        cyc();
        chk("tie_c3_owner", 32'(owner), 2);
        chk("tie_c3_addr", 32'(mem_addr), 2);
        chk("tie_c3_acks", {a_ack, b_ack}, 0);
        cyc();
        chk("tie_c4_owner", 32'(owner), 2);
        chk("tie_c4_acks", {a_ack, b_ack}, 2'b01);
        chk("tie_c4_rdata", 32'(b_rdata), 32'hBBBB);
        b_req = 0;
        cyc();
        chk("tie_c5_owner", 32'(owner), 0);

        // 5: both held for 20 cycles; last served was B so A leads
        a_req = 1; b_req = 1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("alt_a_ack", 32'(a_ack), ((i % 4) == 2) ? 1 : 0);
            chk("alt_b_ack", 32'(b_ack), ((i % 4) == 0) ? 1 : 0);
        end
        a_req = 0; b_req = 0;
        cyc();
        chk("alt_end_owner", 32'(owner), 0);

        // single A access so that last=A before the reset test
        a_req = 1; a_addr = 16'h0001;
        cyc(); cyc();
        chk("pre6_ack", 32'(a_ack), 1);
        a_req = 0;
        cyc();

        // 6: reset during an A write ISSUE kills the access and restores last=B
        a_req = 1; a_we = 1; a_addr = 16'h0030; a_wdata = 16'h5555;
        cyc();
        chk("kill_c1_we", 32'(mem_we), 1);
        reset = 1'b1; a_req = 0; a_we = 0;
        cyc();
        reset = 1'b0;
        chk("kill_c2_we", 32'(mem_we), 0);
        chk("kill_c2_ack", {a_ack, b_ack}, 0);
        chk("kill_c2_owner", 32'(owner), 0);
        cyc();
        chk("kill_c3_ack", {a_ack, b_ack}, 0);
        a_req = 1; a_addr = 16'h0002; b_req = 1; b_addr = 16'h0001;
        cyc();
        chk("kill_tie_owner", 32'(owner), 1);
        cyc();
        chk("kill_tie_acks", {a_ack, b_ack}, 2'b10);
        chk("kill_tie_rdata", 32'(a_rdata), 32'hBBBB);
        a_req = 0;
        cyc();
        chk("kill_tie_b_owner", 32'(owner), 2);
        cyc();
        chk("kill_tie_b_ack", {a_ack, b_ack}, 2'b01);
        chk("kill_tie_b_rdata", 32'(b_rdata), 32'hAAAA);
        b_req = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
